// File: rtl/skin_pkg.sv
// Shared definitions for the skin-mask frame scanner: channel width,
// default image geometry and the scan FSM state encoding.
package skin_pkg;

    localparam int CH_W      = 8;
    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/skin_xy_counter.sv
// Raster position counter: x runs 0..IMG_W-1, then wraps and bumps y.
// 'last' flags the final pixel of the frame at the current position.
module skin_xy_counter
    import skin_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    // Advance the raster position; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/skin_scan_ctrl.sv
// Frame scan controller around an external SkinDecider. Pixels stream in,
// are forwarded to the decider, and each decision comes back as a mask
// strobe tagged with its raster coordinates while skin pixels are counted.
//
// Pixel handshake: a pixel transfers on a rising clk edge where pix_valid
// and pix_ready are both 1 (and abort is 0). pix_ready is registered and is
// 1 only while the scan is running; pix_valid and the pixel data must stay
// stable until the transfer happens.
module skin_scan_ctrl
    import skin_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int DEC_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    input  logic [CH_W-1:0]                  pix_y,
    input  logic [CH_W-1:0]                  pix_cb,
    input  logic [CH_W-1:0]                  pix_cr,
    output logic [CH_W-1:0]                  dec_luma,
    output logic [CH_W-1:0]                  dec_cb,
    output logic [CH_W-1:0]                  dec_cr,
    input  logic                             dec_skin,
    output logic                             mask_valid,
    output logic                             mask_bit,
    output logic [$clog2(IMG_W)-1:0]         mask_x,
    output logic [$clog2(IMG_H)-1:0]         mask_y,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0] skin_count,
    output logic                             busy,
    output logic                             done,
    output scan_state_t                      dbg_state
);

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W * IMG_H + 1);
    localparam int DEPTH = DEC_LAT + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(IMG_W * IMG_H);

    scan_state_t      state;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic             cur_last;
    logic             accept;
    logic             scan_go;
    logic             kill;
    logic             emerge;
    logic [DEPTH-1:0] pipe_v;
    logic [XW-1:0]    pipe_x [DEPTH];
    logic [YW-1:0]    pipe_y [DEPTH];

    // abort outranks both a pixel transfer and a start request
    assign accept    = pix_valid && pix_ready && !abort;
    assign scan_go   = (state == ST_IDLE) && start && !abort;
    assign kill      = abort && ((state == ST_RUN) || (state == ST_DRAIN));
    assign emerge    = pipe_v[DEPTH-1] && !kill;
    assign dbg_state = state;

    skin_xy_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW)
    ) u_xy (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clear (scan_go),
        .x     (cur_x),
        .y     (cur_y),
        .last  (cur_last)
    );

    // Scan sequencing with registered handshake/status outputs and the skin tally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            skin_count <= '0;
        end else begin
            done <= 1'b0;
            if (emerge && (skin_count != CNT_MAX)) begin
                skin_count <= skin_count + CW'(dec_skin);
            end
            unique case (state)
                ST_IDLE: begin
                    if (scan_go) begin
                        state      <= ST_RUN;
                        pix_ready  <= 1'b1;
                        busy       <= 1'b1;
                        skin_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        pix_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if (accept && cur_last) begin
                        state     <= ST_DRAIN;
                        pix_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (pipe_v == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Forward each accepted pixel to the decider; hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dec_luma <= '0;
            dec_cb   <= '0;
            dec_cr   <= '0;
        end else if (accept) begin
            dec_luma <= pix_y;
            dec_cb   <= pix_cb;
            dec_cr   <= pix_cr;
        end
    end

    // Valid bits track pixels in flight through the decider; abort empties them.
    always_ff @(posedge clk) begin
        if (!rst || kill) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= accept;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    // Coordinates ride alongside the valid bits; only meaningful where valid.
    always_ff @(posedge clk) begin
        pipe_x[0] <= cur_x;
        pipe_y[0] <= cur_y;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
    end

    // Pair the emerging slot with the decider result and strobe it out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_valid <= 1'b0;
            mask_bit   <= 1'b0;
            mask_x     <= '0;
            mask_y     <= '0;
        end else begin
            mask_valid <= emerge;
            if (emerge) begin
                mask_bit <= dec_skin;
                mask_x   <= pipe_x[DEPTH-1];
                mask_y   <= pipe_y[DEPTH-1];
            end
        end
    end

endmodule

// File: tb/tb_skin_scan_ctrl.sv
// Bench for skin_scan_ctrl on a 4x2 frame with a one-cycle threshold decider
// (skin when cr >= 150). A transaction-level model predicts every output
// each cycle; directed frames add hand-computed expectations.
module tb_skin_scan_ctrl;
    import skin_pkg::*;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int LAT  = 1;
    localparam int XW   = $clog2(W);
    localparam int YW   = $clog2(H);
    localparam int CW   = $clog2(W * H + 1);
    localparam int NPIX = W * H;
    localparam int QW   = 1 + YW + XW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_y     = 8'd0;
    logic [7:0]    pix_cb    = 8'd0;
    logic [7:0]    pix_cr    = 8'd0;
    logic          pix_ready;
    logic [7:0]    dec_luma;
    logic [7:0]    dec_cb;
    logic [7:0]    dec_cr;
    logic          dec_skin  = 1'b0;
    logic          mask_valid;
    logic          mask_bit;
    logic [XW-1:0] mask_x;
    logic [YW-1:0] mask_y;
    logic [CW-1:0] skin_count;
    logic          busy;
    logic          done;
    scan_state_t   dbg_state;

    skin_scan_ctrl #(.IMG_W(W), .IMG_H(H), .DEC_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_y      (pix_y),
        .pix_cb     (pix_cb),
        .pix_cr     (pix_cr),
        .dec_luma   (dec_luma),
        .dec_cb     (dec_cb),
        .dec_cr     (dec_cr),
        .dec_skin   (dec_skin),
        .mask_valid (mask_valid),
        .mask_bit   (mask_bit),
        .mask_x     (mask_x),
        .mask_y     (mask_y),
        .skin_count (skin_count),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // external decider stand-in: registered threshold on cr
    always @(posedge clk) dec_skin <= (dec_cr >= 8'd150);

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [QW-1:0] pack(input int b, input int y, input int x);
        return QW'(b * (1 << (XW + YW)) + y * (1 << XW) + x);
    endfunction

    // ---------------- reference model ----------------
    // Masks are scheduled LAT+1 edges after acceptance, done LAT+2 edges
    // after the final pixel; abort on a busy scan cancels everything pending.
    logic [QW-1:0] exp_q[$];
    int            exp_t[$];
    bit            m_busy    = 1'b0;
    bit            m_acc     = 1'b0;
    int            m_idx     = 0;
    int            m_done_at = -1;
    int            m_count   = 0;
    logic          exp_ready = 1'b0;
    logic          exp_busy  = 1'b0;
    logic          exp_done  = 1'b0;
    logic          exp_mv    = 1'b0;
    logic          exp_mb    = 1'b0;
    logic [XW-1:0] exp_mx    = '0;
    logic [YW-1:0] exp_my    = '0;
    logic [7:0]    exp_dy    = 8'd0;
    logic [7:0]    exp_dcb   = 8'd0;
    logic [7:0]    exp_dcr   = 8'd0;

    initial begin : ref_model
        bit            busy_q;
        bit            kill;
        bit            take;
        bit            go;
        bit            prev_done;
        logic [QW-1:0] e;
        forever begin
            @(posedge clk);
            cyc++;
            prev_done = exp_done;
            busy_q    = m_busy;
            exp_done  = 1'b0;
            exp_mv    = 1'b0;
            if (rst !== 1'b1) begin
                m_busy = 0; m_acc = 0; m_idx = 0; m_done_at = -1; m_count = 0;
                exp_q.delete(); exp_t.delete();
                exp_mb = 0; exp_mx = '0; exp_my = '0;
                exp_dy = 8'd0; exp_dcb = 8'd0; exp_dcr = 8'd0;
            end else begin
                kill = abort && busy_q;
                if (kill) begin
                    exp_q.delete(); exp_t.delete();
                    m_busy = 0; m_acc = 0; m_done_at = -1;
                end else if (exp_t.size() > 0 && exp_t[0] == cyc) begin
                    e = exp_q.pop_front();
                    void'(exp_t.pop_front());
                    exp_mv = 1'b1;
                    exp_mb = e[QW-1];
                    exp_my = e[XW+YW-1:XW];
                    exp_mx = e[XW-1:0];
                    if (exp_mb && m_count < NPIX) m_count++;
                end
                if (!kill && m_done_at == cyc) begin
                    exp_done = 1'b1; m_busy = 0; m_done_at = -1;
                end
                take = m_acc && pix_valid && !abort;
                if (take) begin
                    exp_q.push_back(pack((pix_cr >= 8'd150) ? 1 : 0, m_idx / W, m_idx % W));
                    exp_t.push_back(cyc + LAT + 1);
                    exp_dy = pix_y; exp_dcb = pix_cb; exp_dcr = pix_cr;
                    m_idx++;
                    if (m_idx == NPIX) begin
                        m_acc = 0;
                        m_done_at = cyc + LAT + 2;
                    end
                end
                go = start && !abort && !busy_q && !prev_done;
                if (go) begin
                    m_busy = 1; m_acc = 1; m_idx = 0; m_count = 0;
                end
            end
            exp_ready = m_acc;
            exp_busy  = m_busy;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("pix_ready", 32'(pix_ready), 32'(exp_ready));
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("done", 32'(done), 32'(exp_done));
                chk("mask_valid", 32'(mask_valid), 32'(exp_mv));
                chk("skin_count", 32'(skin_count), 32'(m_count));
                chk("dec_luma", 32'(dec_luma), 32'(exp_dy));
                chk("dec_cb", 32'(dec_cb), 32'(exp_dcb));
                chk("dec_cr", 32'(dec_cr), 32'(exp_dcr));
                if (exp_mv) begin
                    chk("mask_bit", 32'(mask_bit), 32'(exp_mb));
                    chk("mask_x", 32'(mask_x), 32'(exp_mx));
                    chk("mask_y", 32'(mask_y), 32'(exp_my));
                end
            end
        end
    end

    // ---------------- observation log for directed checks ----------------
    int            obs_t[$];
    logic [QW-1:0] obs_v[$];
    int            acc_t[$];
    int            done_cnt  = 0;
    int            done_edge = -1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mask_valid === 1'b1) begin
                obs_t.push_back(cyc);
                obs_v.push_back(pack(int'(mask_bit), int'(mask_y), int'(mask_x)));
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_edge = cyc;
            end
        end
    end

    // ---------------- driver tasks (entered and left on a negedge) ----------------
    task automatic clear_obs();
        obs_t.delete(); obs_v.delete(); acc_t.delete();
        done_cnt = 0; done_edge = -1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        pix_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_pixel(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        int guard;
        guard = 0;
        pix_valid = 1'b1; pix_y = y; pix_cb = cb; pix_cr = cr;
        while (pix_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", 32'(pix_ready), 32'd1);
        @(negedge clk);
        acc_t.push_back(cyc);
    endtask

    task automatic wait_quiet(input int budget);
        int guard;
        guard = 0;
        pix_valid = 1'b0;
        while ((busy === 1'b1 || done === 1'b1) && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        chk("quiet_wait", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [7:0] crs [8];
        int         n_before;

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(pix_ready), 32'd0);
        chk("rst_count", 32'(skin_count), 32'd0);
        chk("rst_mask_valid", 32'(mask_valid), 32'd0);
        chk("rst_dec_cr", 32'(dec_cr), 32'd0);
        rst = 1'b1;
        idle(2);

        // full frame, back-to-back, cr=200 on odd pixels
        clear_obs();
        pulse_start();
        for (int k = 0; k < NPIX; k++) begin
            send_pixel(8'(k * 10), 8'd128, (k % 2 == 1) ? 8'd200 : 8'd0);
        end
        wait_quiet(20);
        chk("f1_pulses", 32'(obs_t.size()), 32'd8);
        chk("f1_back_to_back", 32'(acc_t[7] - acc_t[0]), 32'd7);
        chk("f1_first_lat", 32'(obs_t[0]), 32'(acc_t[0] + 2));
        for (int k = 0; k < NPIX; k++) begin
            chk("f1_mask", 32'(obs_v[k]), 32'(pack(k % 2, k / 4, k % 4)));
        end
        chk("f1_count", 32'(skin_count), 32'd4);
        chk("f1_done_pulses", 32'(done_cnt), 32'd1);
        chk("f1_done_at", 32'(done_edge), 32'(acc_t[7] + 3));

        // stall after pixel 3 with a start pulse inside it; threshold boundary values
        crs = '{8'd160, 8'd149, 8'd150, 8'd255, 8'd0, 8'd151, 8'd10, 8'd150};
        clear_obs();
        pulse_start();
        for (int k = 0; k < 3; k++) send_pixel(8'd50, 8'd60, crs[k]);
        idle(2);
        pulse_start();
        idle(2);
        chk("stall_count", 32'(skin_count), 32'd2);
        for (int k = 3; k < NPIX; k++) send_pixel(8'd70, 8'd80, crs[k]);
        wait_quiet(20);
        chk("stall_pulses", 32'(obs_t.size()), 32'd8);
        chk("stall_gap", 32'(obs_t[3] - obs_t[2]), 32'd6);
        chk("wrap_x3y0", 32'(obs_v[3]), 32'(pack(1, 0, 3)));
        chk("wrap_x0y1", 32'(obs_v[4]), 32'(pack(0, 1, 0)));
        chk("stall_count_final", 32'(skin_count), 32'd5);
        chk("stall_done_pulses", 32'(done_cnt), 32'd1);

        // abort after 5 pixels while a 6th is offered
        clear_obs();
        pulse_start();
        for (int k = 0; k < 5; k++) send_pixel(8'd1, 8'd2, 8'd200);
        pix_valid = 1'b1; pix_cr = 8'd200;
        pulse_abort();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(pix_ready), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        idle(6);
        chk("abort_pulses", 32'(obs_t.size()), 32'd3);
        chk("abort_count", 32'(skin_count), 32'd3);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // fresh frame after the abort
        clear_obs();
        pulse_start();
        for (int k = 0; k < NPIX; k++) send_pixel(8'(k), 8'(k + 1), 8'd200);
        wait_quiet(20);
        chk("post_abort_pulses", 32'(obs_t.size()), 32'd8);
        chk("post_abort_count", 32'(skin_count), 32'd8);
        chk("post_abort_done", 32'(done_cnt), 32'd1);

        // one-cycle reset mid-frame
        clear_obs();
        pulse_start();
        for (int k = 0; k < 3; k++) send_pixel(8'd9, 8'd9, 8'd200);
        pulse_reset();
        n_before = obs_t.size();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(pix_ready), 32'd0);
        chk("mrst_count", 32'(skin_count), 32'd0);
        chk("mrst_mask_valid", 32'(mask_valid), 32'd0);
        chk("mrst_mask_xy", 32'({mask_x, mask_y, mask_bit}), 32'd0);
        chk("mrst_dec", 32'({dec_luma, dec_cb, dec_cr}), 32'd0);
        idle(6);
        chk("mrst_no_pulses", 32'(obs_t.size()), 32'(n_before));
        chk("mrst_no_done", 32'(done_cnt), 32'd0);

        // randomized frames: stalls, stray starts, aborts, resets
        for (int f = 0; f < 30; f++) begin
            bit stop;
            stop = 1'b0;
            pulse_start();
            for (int k = 0; k < NPIX && !stop; k++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 4) begin
                    pix_valid = 1'b1;
                    pix_cr = 8'($urandom_range(0, 255));
                    pulse_abort();
                    stop = 1'b1;
                end else if (r < 7) begin
                    pulse_reset();
                    stop = 1'b1;
                end else begin
                    if (r < 30) begin
                        idle($urandom_range(1, 4));
                        if (r < 14) pulse_start();
                    end
                    send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                               8'($urandom_range(0, 255)));
                end
            end
            wait_quiet(40);
            if ($urandom_range(0, 3) == 0) pulse_abort();
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/skin_scan_ctrl.md
SKIN_SCAN_CTRL -- requirements
Module: skin_scan_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 160: pixels per row.
REQ-002 The block SHALL have parameter IMG_H, default 120: rows per frame.
REQ-003 The block SHALL have parameter DEC_LAT, default 1: cycles from decider input to its matching skin_pix result.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-low (0 = reset).
REQ-006 The block SHALL have port start, input, 1: one-cycle frame-scan request.
REQ-007 The block SHALL have port abort, input, 1: cancel the scan in progress.
REQ-008 The block SHALL have ports pix_valid (input, 1), pix_ready (output, 1) and pix_y, pix_cb, pix_cr (inputs, 8 each): upstream YCbCr pixel stream.
REQ-009 The block SHALL have ports dec_luma, dec_cb, dec_cr (outputs, 8 each): registered drive to the SkinDecider luma_ch/cb_ch/cr_ch.
REQ-010 The block SHALL have port dec_skin, input, 1: SkinDecider skin_pix.
REQ-011 The block SHALL have ports mask_valid (output, 1), mask_bit (output, 1), mask_x (output, clog2(IMG_W)) and mask_y (output, clog2(IMG_H)): per-pixel mask strobe.
REQ-012 The block SHALL have ports skin_count (output, clog2(IMG_W*IMG_H+1)), busy (output, 1) and done (output, 1).

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-014 IDLE: start=1 SHALL go to RUN, clear the x/y counters and clear skin_count.
REQ-015 RUN: pix_ready=1; a pixel SHALL be accepted on any cycle with pix_valid and pix_ready both 1.
REQ-016 An accepted pixel SHALL appear on dec_* on the next cycle, together with its x/y, which is pushed into a DEC_LAT+1-deep valid/coordinate pipeline.
REQ-017 dec_* SHALL hold their last value when no pixel is accepted.
REQ-018 For each pipeline slot emerging valid, mask_valid SHALL pulse 1 for one cycle with mask_bit=dec_skin and the matching mask_x/mask_y, and skin_count SHALL increment by dec_skin.
REQ-019 Total pixel-in to mask_valid latency SHALL be DEC_LAT+1 cycles, and order SHALL be preserved.
REQ-020 x SHALL increment per accepted pixel; at IMG_W-1, x SHALL wrap to 0 and y SHALL increment.
REQ-021 Acceptance of pixel (IMG_W-1, IMG_H-1) SHALL move the FSM to DRAIN, and pix_ready SHALL be 0 from the next cycle on.
REQ-022 DRAIN SHALL last until the pipeline is empty and then go to DONE.
REQ-023 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-024 skin_count SHALL hold its final value until the next accepted start.
REQ-025 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-026 start SHALL be ignored when not in IDLE.
REQ-027 abort SHALL have priority over start and over pixel acceptance.
REQ-028 abort in RUN or DRAIN SHALL, next cycle: return the FSM to IDLE, flush the pipeline valids (no further mask_valid), keep done=0, and freeze skin_count.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 pix_valid=0 in RUN SHALL stall the scan indefinitely with no counter change.
REQ-031 skin_count SHALL saturate at IMG_W*IMG_H and never wrap.

Reset
REQ-032 rst=0 sampled on a posedge SHALL set: FSM=IDLE; x=y=0; pipeline valids=0; pix_ready=0; mask_valid=0; mask_bit=0; mask_x=mask_y=0; dec_luma=dec_cb=dec_cr=0; skin_count=0; busy=0; done=0.
REQ-033 Reset mid-scan SHALL discard all in-flight pixels, and no mask_valid or done SHALL follow.
REQ-034 rst SHALL take precedence over start and abort.

Structure
REQ-035 The shared package skin_pkg SHALL hold the state enumeration, the 8-bit channel width constant and the IMG_W/IMG_H defaults.
REQ-036 The x/y wrap counter SHALL be the sub-module skin_xy_counter (inc, clear, x, y, last).
REQ-037 SkinDecider SHALL stay external, connected through the dec_* ports.

Verification (IMG_W=4, IMG_H=2, DEC_LAT=1, model decider: skin=1 iff cr>=150)
REQ-038 Full frame: start, then 8 back-to-back pixels, cr=200 at odd indices and 0 otherwise -> 8 mask_valid pulses, first 2 cycles after first acceptance, coordinates (0,0)..(3,1) in order, mask_bit alternating 0,1, skin_count=4, a single done pulse 3 cycles after the last acceptance.
REQ-039 Stall: pix_valid low for 5 cycles after pixel 3 -> no mask_valid gap beyond the stall, coordinates continuous, skin_count unchanged during the stall.
REQ-040 Row wrap: after the 4th pixel, mask_x=3/mask_y=0, and the next pixel reports mask_x=0/mask_y=1.
REQ-041 Abort after 5 pixels -> IDLE next cycle, at most the already-emerged pulses, done never 1, skin_count frozen; a new start then completes a full 8-pixel frame correctly.
REQ-042 start pulsed in RUN -> ignored (count and coordinates unaffected); rst=0 for 1 cycle mid-frame -> all outputs at reset values next cycle, no done.
